// File: rtl/ripple_adder_4bit.sv
// ripple_adder_4bit
//   Unsigned ripple-carry adder with carry-in and carry-out. It is a chain of
//   full-adder cells. Each cell is two half adders and an OR, and the carry
//   ripples from LSB to MSB. The sum and carry-out are combinational. A
//   registered copy of the result, with overflow and zero flags, is also
//   provided for pipelined datapaths.
// Ports
//   clk          rising-edge clock for the result registers
//   rst          async active-high reset; clears the result registers only
//   a, b         unsigned operands
//   carry_in     carry into bit 0
//   sum          combinational (a + b + carry_in) mod 2**WIDTH
//   carry_out    combinational carry out of the MSB cell
//   sum_q        registered sum
//   carry_out_q  registered carry_out
//   overflow_q   registered signed overflow (carry into MSB ^ carry out of MSB)
//   zero_q       registered sum == 0 flag (carry ignored)
module ripple_adder_4bit #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic [WIDTH-1:0] sum_q,
    output logic             carry_out_q,
    output logic             overflow_q,
    output logic             zero_q
);

    // carry[i] is the carry into cell i; carry[WIDTH] leaves the MSB cell
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_w;

    assign carry[0] = carry_in;

    // Full-adder cells: half adder on (a,b), half adder on (partial, carry), OR of carries
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic ha0_s;
        logic ha0_c;
        logic ha1_s;
        logic ha1_c;

        assign ha0_s        = a[i] ^ b[i];
        assign ha0_c        = a[i] & b[i];
        assign ha1_s        = ha0_s ^ carry[i];
        assign ha1_c        = ha0_s & carry[i];
        assign sum_w[i]     = ha1_s;
        assign carry[i+1]   = ha0_c | ha1_c;
    end

    assign sum       = sum_w;
    assign carry_out = carry[WIDTH];

    logic [WIDTH-1:0] sum_d;
    logic             carry_out_d;
    logic             overflow_d;
    logic             zero_d;

    // Next values for the result registers
    always_comb begin
        sum_d       = sum_w;
        carry_out_d = carry[WIDTH];
        overflow_d  = carry[WIDTH-1] ^ carry[WIDTH];
        zero_d      = (sum_w == WIDTH'(0));
    end

    // Result registers; zero_q resets to 0 even though sum_q resets to 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
        end
    end

endmodule

// File: tb/tb_ripple_adder_4bit.sv
// tb_ripple_adder_4bit
//   Self-checking bench for ripple_adder_4bit. It applies a table of directed
//   vectors, an exhaustive sweep, random vectors against an arithmetic
//   reference model, and asynchronous-reset sequences.
module tb_ripple_adder_4bit;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       carry_in;
    logic [3:0] sum;
    logic       carry_out;
    logic [3:0] sum_q;
    logic       carry_out_q;
    logic       overflow_q;
    logic       zero_q;

    int checks = 0;
    int errors = 0;

    ripple_adder_4bit #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .a           (a),
        .b           (b),
        .carry_in    (carry_in),
        .sum         (sum),
        .carry_out   (carry_out),
        .sum_q       (sum_q),
        .carry_out_q (carry_out_q),
        .overflow_q  (overflow_q),
        .zero_q      (zero_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] sum;
        logic       co;
        logic       ovf;
        logic       zero;
    } vec_t;

    typedef struct {
        logic [3:0] sum;
        logic       co;
        logic       ovf;
        logic       zero;
    } res_t;

    // Reference: plain unsigned and signed integer arithmetic
    function automatic res_t model(input logic [3:0] xa, input logic [3:0] xb, input logic xc);
        res_t r;
        int   u;
        int   s;
        u      = int'(xa) + int'(xb) + int'(xc);
        s      = int'($signed(xa)) + int'($signed(xb)) + int'(xc);
        r.sum  = 4'(u % 16);
        r.co   = (u >= 16);
        r.ovf  = (s > 7) || (s < -8);
        r.zero = ((u % 16) == 0);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (a=%0d b=%0d cin=%0d)",
                     name, act, exp, a, b, carry_in);
        end
    endtask

    // Drive a vector mid-cycle, check comb, then check registered after next edge
    task automatic run_vec(input logic [3:0] xa, input logic [3:0] xb, input logic xc,
                           input logic [3:0] esum, input logic eco,
                           input logic eovf, input logic ezero);
        @(negedge clk);
        a = xa; b = xb; carry_in = xc;
        #1;
        check("sum", 32'(sum), 32'(esum));
        check("carry_out", 32'(carry_out), 32'(eco));
        @(posedge clk);
        #1;
        check("sum_q", 32'(sum_q), 32'(esum));
        check("carry_out_q", 32'(carry_out_q), 32'(eco));
        check("overflow_q", 32'(overflow_q), 32'(eovf));
        check("zero_q", 32'(zero_q), 32'(ezero));
    endtask

    task automatic run_model(input logic [3:0] xa, input logic [3:0] xb, input logic xc);
        res_t r;
        r = model(xa, xb, xc);
        run_vec(xa, xb, xc, r.sum, r.co, r.ovf, r.zero);
    endtask

    task automatic check_q_zero(input string tag);
        check({tag, "_sum_q"}, 32'(sum_q), 32'd0);
        check({tag, "_carry_out_q"}, 32'(carry_out_q), 32'd0);
        check({tag, "_overflow_q"}, 32'(overflow_q), 32'd0);
        check({tag, "_zero_q"}, 32'(zero_q), 32'd0);
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{4'd0,  4'd0,  1'b0, 4'd0,  1'b0, 1'b0, 1'b1};
        vecs[1] = '{4'd0,  4'd0,  1'b1, 4'd1,  1'b0, 1'b0, 1'b0};
        vecs[2] = '{4'd1,  4'd1,  1'b0, 4'd2,  1'b0, 1'b0, 1'b0};
        vecs[3] = '{4'd1,  4'd1,  1'b1, 4'd3,  1'b0, 1'b0, 1'b0};
        vecs[4] = '{4'd3,  4'd6,  1'b0, 4'd9,  1'b0, 1'b1, 1'b0};
        vecs[5] = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{4'd15, 4'd0,  1'b1, 4'd0,  1'b1, 1'b0, 1'b1};
        vecs[7] = '{4'd7,  4'd1,  1'b0, 4'd8,  1'b0, 1'b1, 1'b0};
        vecs[8] = '{4'd8,  4'd8,  1'b0, 4'd0,  1'b1, 1'b1, 1'b1};

        // Reset state: registered outputs all 0, including zero_q
        rst = 1'b1; a = 4'd0; b = 4'd0; carry_in = 1'b0;
        @(posedge clk);
        #1;
        check_q_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 9; i++)
            run_vec(vecs[i].a, vecs[i].b, vecs[i].cin,
                    vecs[i].sum, vecs[i].co, vecs[i].ovf, vecs[i].zero);

        // Exhaustive sweep
        for (int ia = 0; ia < 16; ia++)
            for (int ib = 0; ib < 16; ib++)
                for (int ic = 0; ic < 2; ic++)
                    run_model(4'(ia), 4'(ib), 1'(ic));

        // Random vectors
        for (int n = 0; n < 200; n++)
            run_model(4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)));

        // Async reset mid-cycle with a nonzero result held
        run_vec(4'd3, 4'd6, 1'b0, 4'd9, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_q_zero("async_rst");
        check("rst_sum_comb", 32'(sum), 32'd9);
        check("rst_carry_out_comb", 32'(carry_out), 32'd0);
        @(posedge clk);
        #1;
        check_q_zero("rst_held");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_q_zero("rst_released");
        @(posedge clk);
        #1;
        check("restored_sum_q", 32'(sum_q), 32'd9);
        check("restored_overflow_q", 32'(overflow_q), 32'd1);
        check("restored_zero_q", 32'(zero_q), 32'd0);

        // Reset pulse while a carry-out / zero result is held
        run_vec(4'd15, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_q_zero("pulse2");
        check("pulse2_carry_out_comb", 32'(carry_out), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("pulse2_carry_out_q", 32'(carry_out_q), 32'd1);
        check("pulse2_zero_q", 32'(zero_q), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
